// File: rtl/cnn_pkg.sv
// Shared constants for the first conv layer and its window generator.
package cnn_pkg;

    localparam int FEAT_L1 = 28;
    localparam int PIX_B   = 8;
    localparam int KSZ     = 3;
    localparam int WIN_W   = KSZ * KSZ * PIX_B;

endpackage : cnn_pkg

// File: rtl/line_buf.sv
// One image row of storage. The read port is asynchronous on the address
// presented this cycle, so a read and a write to the same address in the
// same cycle return the old contents; the new data lands on the clock edge.
module line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = FEAT_L1,
    parameter int W     = PIX_B,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // read-before-write: the old word is visible until the edge commits the new one
    assign o_rdata = mem_q[i_addr];

    // contents need no reset; every location is rewritten before it is used
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule : line_buf

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 window converter feeding the first conv layer.
// Two line buffers supply the two rows above the incoming pixel; a 3x3
// shift register forms the window, emitted one cycle after its bottom-right
// pixel arrives.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int F = FEAT_L1,
    parameter int B = PIX_B
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [B-1:0]           i_pixel,
    input  logic                   i_pixel_valid,
    output logic [KSZ*KSZ*B-1:0]   o_pixel_data,
    output logic                   o_pixel_data_valid,
    output logic                   o_frame_done
);

    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam int RW = KSZ * B;
    localparam int OW = KSZ * KSZ * B;
    localparam logic [CW-1:0] LAST      = CW'(F - 1);
    localparam logic [CW-1:0] FIRST_WIN = CW'(KSZ - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [RW-1:0] top_row_q, top_row_d;
    logic [RW-1:0] mid_row_q, mid_row_d;
    logic [RW-1:0] bot_row_q, bot_row_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic [B-1:0]  lb_top;
    logic [B-1:0]  lb_mid;

    // lb0 holds row r-2 and is refilled from lb1 as lb1 takes the new row
    line_buf #(.DEPTH(F), .W(B)) u_lb0 (
        .i_clk   (i_clk),
        .i_we    (i_pixel_valid),
        .i_addr  (col_q),
        .i_wdata (lb_mid),
        .o_rdata (lb_top)
    );

    line_buf #(.DEPTH(F), .W(B)) u_lb1 (
        .i_clk   (i_clk),
        .i_we    (i_pixel_valid),
        .i_addr  (col_q),
        .i_wdata (i_pixel),
        .o_rdata (lb_mid)
    );

    // position counters, window shift and output formation on accepted pixels
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        top_row_d = top_row_q;
        mid_row_d = mid_row_q;
        bot_row_d = bot_row_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        if (i_pixel_valid) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // column 0 sits in the low bits, so the newest pixel enters at the top
            top_row_d = {lb_top,  top_row_q[RW-1:B]};
            mid_row_d = {lb_mid,  mid_row_q[RW-1:B]};
            bot_row_d = {i_pixel, bot_row_q[RW-1:B]};

            // columns 0/1 never close a window, so no window straddles two rows
            if (row_q >= FIRST_WIN && col_q >= FIRST_WIN) begin
                valid_d = 1'b1;
                data_d  = {bot_row_d, mid_row_d, top_row_d};
                done_d  = (row_q == LAST) && (col_q == LAST);
            end
        end
    end

    // state registers with synchronous reset; line buffers are left alone
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q     <= '0;
            row_q     <= '0;
            top_row_q <= '0;
            mid_row_q <= '0;
            bot_row_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            top_row_q <= top_row_d;
            mid_row_q <= mid_row_d;
            bot_row_q <= bot_row_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_frame_done       = done_q;

endmodule : conv_window_gen

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a frame-array model checked every cycle, plus
// literal expectations for the ramp frame and a separate F=3 instance.
module tb_conv_window_gen;

    localparam int F  = 28;
    localparam int NP = F * F;
    localparam int WPF = (F - 2) * (F - 2);

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_pixel;
    logic        i_pixel_valid;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_frame_done;

    logic        t_rst;
    logic [7:0]  t_pixel;
    logic        t_valid;
    logic [71:0] t_data;
    logic        t_dv;
    logic        t_done;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    conv_window_gen #(.F(F), .B(8)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel            (i_pixel),
        .i_pixel_valid      (i_pixel_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_frame_done       (o_frame_done)
    );

    conv_window_gen #(.F(3), .B(8)) dut3 (
        .i_clk              (i_clk),
        .i_rst              (t_rst),
        .i_pixel            (t_pixel),
        .i_pixel_valid      (t_valid),
        .o_pixel_data       (t_data),
        .o_pixel_data_valid (t_dv),
        .o_frame_done       (t_done)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: window = 3x3 block of the stored frame ----------
    logic [7:0]  fm [F][F];
    int          mk = 0;
    logic        exp_v = 1'b0;
    logic        exp_done = 1'b0;
    logic [71:0] exp_data = '0;
    bit          chk_en = 1'b0;

    always @(posedge i_clk) begin
        int mr, mc;
        exp_v    = 1'b0;
        exp_done = 1'b0;
        if (i_rst) begin
            mk       = 0;
            exp_data = '0;
        end else if (i_pixel_valid) begin
            mr = mk / F;
            mc = mk % F;
            fm[mr][mc] = i_pixel;
            if (mr >= 2 && mc >= 2) begin
                exp_v = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_data[(i*3+j)*8 +: 8] = fm[mr-2+i][mc-2+j];
                exp_done = (mk == NP - 1);
            end
            mk = (mk + 1) % NP;
        end
    end

    logic [71:0] got_q[$];
    bit          gotd_q[$];

    // every-cycle comparison against the model; also logs emitted windows
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("valid", {71'd0, o_pixel_data_valid}, {71'd0, exp_v});
            check("data", o_pixel_data, exp_data);
            check("frame_done", {71'd0, o_frame_done}, {71'd0, exp_done});
            if (o_pixel_data_valid) begin
                got_q.push_back(o_pixel_data);
                gotd_q.push_back(o_frame_done);
            end
        end
    end

    int          t3_cnt = 0;
    logic [71:0] t3_data = '0;
    logic        t3_done = 1'b0;

    always @(negedge i_clk) begin
        if (t_dv) begin
            t3_cnt++;
            t3_data = t_data;
            t3_done = t_done;
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input logic v, input logic [7:0] p);
        i_pixel_valid = v;
        i_pixel       = p;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send3(input logic v, input logic [7:0] p);
        t_valid = v;
        t_pixel = p;
        @(posedge i_clk);
        #1;
    endtask

    task automatic ramp_pixels(input int first, input int last, input int gap_pct);
        for (int k = first; k <= last; k++) begin
            while (int'($urandom_range(99)) < gap_pct)
                send(1'b0, 8'($urandom));
            send(1'b1, 8'(k));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 8'h00);
    endtask

    task automatic clear_log();
        got_q.delete();
        gotd_q.delete();
    endtask

    logic [71:0] ref_q[$];

    task automatic cmp_ref(input string name, input int offset);
        int mism;
        mism = 0;
        for (int k = 0; k < WPF; k++)
            if (offset + k >= got_q.size() || got_q[offset+k] !== ref_q[k]) mism++;
        check(name, 72'(mism), 72'd0);
    endtask

    function automatic int count_done();
        int n;
        n = 0;
        foreach (gotd_q[k]) if (gotd_q[k]) n++;
        return n;
    endfunction

    // ---------------- directed sequence --------------------------------------
    initial begin
        i_rst = 1'b1; i_pixel_valid = 1'b0; i_pixel = '0;
        t_rst = 1'b1; t_valid = 1'b0; t_pixel = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset data", o_pixel_data, 72'd0);
        check("reset valid", {71'd0, o_pixel_data_valid}, 72'd0);
        check("reset done", {71'd0, o_frame_done}, 72'd0);
        i_rst = 1'b0;
        t_rst = 1'b0;
        chk_en = 1'b1;

        // continuous ramp frame; first window comes one cycle after pixel (2,2)
        ramp_pixels(0, 2*F + 1, 0);
        send(1'b1, 8'(2*F + 2));
        @(negedge i_clk);
        check("first window latency", {71'd0, o_pixel_data_valid}, 72'd1);
        check("first window value", o_pixel_data, 72'h3A39381E1D1C020100);
        #1;
        ramp_pixels(2*F + 3, NP - 1, 0);
        idle(4);
        check("windows per frame", 72'(got_q.size()), 72'(WPF));
        check("done pulses", 72'(count_done()), 72'd1);
        if (got_q.size() == WPF) begin
            check("row2 last window byte8", 72'(got_q[25][71:64]), 72'd27 + 72'd56);
            check("row boundary window", got_q[26], 72'h5655543A39381E1D1C);
            check("row boundary byte0", 72'(got_q[26][7:0]), 72'd28);
            check("last window byte8", 72'(got_q[WPF-1][71:64]), 72'h0F);
            check("done on last window", 72'(gotd_q[WPF-1]), 72'd1);
        end
        ref_q = got_q;
        clear_log();

        // same frame with ~40% valid density
        ramp_pixels(0, NP - 1, 60);
        idle(4);
        check("gapped window count", 72'(got_q.size()), 72'(WPF));
        cmp_ref("gapped sequence", 0);
        clear_log();

        // two frames back to back
        ramp_pixels(0, NP - 1, 0);
        ramp_pixels(0, NP - 1, 0);
        idle(4);
        check("b2b window count", 72'(got_q.size()), 72'(2*WPF));
        check("b2b done pulses", 72'(count_done()), 72'd2);
        if (got_q.size() == 2*WPF)
            check("b2b second first window", got_q[WPF], 72'h3A39381E1D1C020100);
        cmp_ref("b2b frame0", 0);
        cmp_ref("b2b frame1", WPF);
        clear_log();

        // reset after pixel (10,5), then a clean frame
        ramp_pixels(0, 10*F + 5, 0);
        i_rst = 1'b1;
        send(1'b0, 8'h00);
        check("midreset data", o_pixel_data, 72'd0);
        check("midreset valid", {71'd0, o_pixel_data_valid}, 72'd0);
        check("midreset done", {71'd0, o_frame_done}, 72'd0);
        i_rst = 1'b0;
        clear_log();
        ramp_pixels(0, NP - 1, 0);
        idle(4);
        check("post-reset window count", 72'(got_q.size()), 72'(WPF));
        check("post-reset done pulses", 72'(count_done()), 72'd1);
        cmp_ref("post-reset sequence", 0);

        // F=3: one window holding pixels 1..9
        for (int k = 1; k <= 8; k++) send3(1'b1, 8'(k));
        send3(1'b1, 8'd9);
        t_valid = 1'b0;
        @(negedge i_clk);
        check("f3 latency", {71'd0, t_dv}, 72'd1);
        check("f3 done coincident", {71'd0, t_done}, 72'd1);
        repeat (4) @(posedge i_clk);
        #1;
        check("f3 window count", 72'(t3_cnt), 72'd1);
        check("f3 window", t3_data, 72'h090807060504030201);
        check("f3 window done", {71'd0, t3_done}, 72'd1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_conv_window_gen
